// File: rtl/tlp_encap_arb_pkg.sv
// Shared definitions for the captured-TLP FIFO word and the encapsulator
// arbiter. The 74-bit FIFO word carries one AXI-stream beat:
//   [73:66] tkeep, [65:2] tdata, [1] tlast, [0] tuser.
package tlp_encap_arb_pkg;

  localparam int TCAP_FIFO_W = 74;
  localparam int TUSER_BIT   = 0;
  localparam int TLAST_BIT   = 1;
  localparam int TDATA_LSB   = 2;
  localparam int TDATA_W     = 64;
  localparam int TKEEP_LSB   = 66;
  localparam int TKEEP_W     = 8;

  // Packed so the field order maps directly onto the FIFO word bits.
  typedef struct packed {
    logic [TKEEP_W-1:0] tkeep;
    logic [TDATA_W-1:0] tdata;
    logic               tlast;
    logic               tuser;
  } tcap_word_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // True when the word closes a packet.
  function automatic logic word_is_last(input logic [TCAP_FIFO_W-1:0] w);
    return w[TLAST_BIT];
  endfunction

endpackage

// File: rtl/tlp_encap_arb_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting one past `last` (wrapping modulo N_SRC) and reports the
// first requester found.
// Ports:
//   req     in  N_SRC  request vector
//   last    in  SEL_W  index granted most recently (lowest priority now)
//   gnt_idx out SEL_W  chosen index (0 when nothing requests)
//   gnt_any out 1      some request is present
module rr_pick #(
  parameter int N_SRC = 2,
  parameter int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Priority scan: offset 1 is highest priority, offset N_SRC (last itself) lowest.
  always_comb begin
    logic hit;
    gnt_idx = {SEL_W{1'b0}};
    gnt_any = 1'b0;
    hit     = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      hit = 1'b0;
      // Inner loop keeps every req select a constant index.
      for (int j = 0; j < N_SRC; j++) begin
        hit = (((int'(last) + k) % N_SRC) == j) ? req[j] : hit;
      end
      gnt_idx = (!gnt_any && hit) ? SEL_W'((int'(last) + k) % N_SRC) : gnt_idx;
      gnt_any = gnt_any | hit;
    end
  end

endmodule

// File: rtl/tlp_encap_arb.sv
// Per-packet round-robin arbiter sharing one encapsulator between N_SRC
// captured-TLP FWFT FIFOs. A source is locked from its first word until its
// tlast word has been consumed, then arbitration runs again.
// Ports:
//   clk156, sys_rst      clock, async active-high reset
//   src_rd_en/src_dout/src_empty   per-source FWFT FIFO interfaces
//   rd_en/dout/empty      FWFT read interface toward the encapsulator
//   grant_sel/grant_valid locked source index and its qualifier
//   pkt_cnt               per-source forwarded packet counters (wrapping)
//   underrun              sticky per-source read-while-empty flags
module tlp_encap_arb
  import tlp_encap_arb_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter int CNT_W = 32
) (
  input  logic                         clk156,
  input  logic                         sys_rst,
  output logic [N_SRC-1:0]             src_rd_en,
  input  logic [N_SRC*TCAP_FIFO_W-1:0] src_dout,
  input  logic [N_SRC-1:0]             src_empty,
  input  logic                         rd_en,
  output logic [TCAP_FIFO_W-1:0]       dout,
  output logic                         empty,
  output logic [SEL_W-1:0]             grant_sel,
  output logic                         grant_valid,
  output logic [N_SRC*CNT_W-1:0]       pkt_cnt,
  output logic [N_SRC-1:0]             underrun
);

  arb_state_t       state_q;
  logic [SEL_W-1:0] grant_sel_q;
  logic             grant_valid_q;
  logic [SEL_W-1:0] last_grant_q;
  logic [CNT_W-1:0] pkt_cnt_q [N_SRC];
  logic [N_SRC-1:0] underrun_q;

  tcap_word_t       sel_word_s;
  logic             sel_empty_s;
  logic [N_SRC-1:0] sel_onehot_s;
  logic             lock_s;
  logic             consume_s;
  logic             underrun_hit_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_any_s;

  rr_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (~src_empty),
    .last    (last_grant_q),
    .gnt_idx (pick_idx_s),
    .gnt_any (pick_any_s)
  );

  // Route the granted source's word and empty flag (constant-index mux).
  always_comb begin
    sel_word_s   = '0;
    sel_empty_s  = 1'b1;
    sel_onehot_s = {N_SRC{1'b0}};
    for (int s = 0; s < N_SRC; s++) begin
      if (grant_sel_q == SEL_W'(s)) begin
        sel_word_s      = src_dout[TCAP_FIFO_W*s +: TCAP_FIFO_W];
        sel_empty_s     = src_empty[s];
        sel_onehot_s[s] = 1'b1;
      end else begin
        sel_onehot_s[s] = 1'b0;
      end
    end
  end

  // Encapsulator-facing view. empty/dout depend only on state and the FIFO,
  // never on rd_en; src_rd_en is gated so an empty FIFO is never popped.
  always_comb begin
    lock_s         = (state_q == ARB_LOCK);
    consume_s      = lock_s & rd_en & ~sel_empty_s;
    underrun_hit_s = lock_s & rd_en & sel_empty_s;
    dout           = lock_s ? sel_word_s : {TCAP_FIFO_W{1'b0}};
    empty          = lock_s ? sel_empty_s : 1'b1;
    src_rd_en      = consume_s ? sel_onehot_s : {N_SRC{1'b0}};
  end

  // Arbitration FSM, grant registers, packet counters and underrun flags.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= ARB_IDLE;
      grant_sel_q   <= {SEL_W{1'b0}};
      grant_valid_q <= 1'b0;
      // Pointing at the highest index makes source 0 the first winner.
      last_grant_q  <= SEL_W'(N_SRC - 1);
      for (int s = 0; s < N_SRC; s++) begin
        pkt_cnt_q[s] <= {CNT_W{1'b0}};
      end
      underrun_q    <= {N_SRC{1'b0}};
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any_s) begin
            grant_sel_q   <= pick_idx_s;
            grant_valid_q <= 1'b1;
            state_q       <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (underrun_hit_s) begin
            underrun_q <= underrun_q | sel_onehot_s;
          end
          if (consume_s && word_is_last(sel_word_s)) begin
            for (int s = 0; s < N_SRC; s++) begin
              if (sel_onehot_s[s]) begin
                pkt_cnt_q[s] <= pkt_cnt_q[s] + 1'b1;
              end
            end
            last_grant_q  <= grant_sel_q;
            grant_valid_q <= 1'b0;
            state_q       <= ARB_IDLE;
          end
        end
        default: begin
          state_q       <= ARB_IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_sel   = grant_sel_q;
  assign grant_valid = grant_valid_q;
  assign underrun    = underrun_q;

  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    assign pkt_cnt[CNT_W*g +: CNT_W] = pkt_cnt_q[g];
  end

endmodule

// File: tb/tb_tlp_encap_arb.sv
// Randomized self-checking bench for tlp_encap_arb (2 sources, 4-bit counters).
// Source FIFOs are bench queues presented FWFT-style; a packet-level model
// (locked / granted index / last grant / counters) predicts every output.
module tb_tlp_encap_arb;
  import tlp_encap_arb_pkg::*;

  localparam int N  = 2;
  localparam int CW = 4;
  localparam int W  = TCAP_FIFO_W;

  logic             clk156 = 1'b0;
  logic             sys_rst;
  logic [N-1:0]     src_rd_en;
  logic [N*W-1:0]   src_dout;
  logic [N-1:0]     src_empty;
  logic             rd_en;
  logic [W-1:0]     dout;
  logic             empty;
  logic [0:0]       grant_sel;
  logic             grant_valid;
  logic [N*CW-1:0]  pkt_cnt;
  logic [N-1:0]     underrun;

  tlp_encap_arb #(.N_SRC(N), .SEL_W(1), .CNT_W(CW)) dut (
    .clk156      (clk156),
    .sys_rst     (sys_rst),
    .src_rd_en   (src_rd_en),
    .src_dout    (src_dout),
    .src_empty   (src_empty),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .grant_sel   (grant_sel),
    .grant_valid (grant_valid),
    .pkt_cnt     (pkt_cnt),
    .underrun    (underrun)
  );

  always #5 clk156 = ~clk156;

  // Source FIFO contents and per-cycle driven values.
  logic [W-1:0] fq [N][$];
  logic [W-1:0] drv_w [N];
  logic         drv_e [N];

  // Reference model state.
  bit     locked;
  int     gsel;
  int     lastg;
  int     wcnt;
  int     cnt [N];
  bit [N-1:0] und;
  int     grant_log [$];

  int     rd_pct;
  int     stall_pct;
  bit [N-1:0] force_empty;

  int     total = 0;
  int     bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_word(input bit last);
    logic [W-1:0] w;
    w = '0;
    w[TKEEP_LSB +: TKEEP_W] = 8'($urandom);
    w[TDATA_LSB +: TDATA_W] = {$urandom, $urandom};
    w[TLAST_BIT]            = last;
    w[TUSER_BIT]            = 1'($urandom);
    return w;
  endfunction

  function automatic logic [W-1:0] junk(input int s);
    return {8'hA5, 56'h0, 8'(s), 2'b10};
  endfunction

  task automatic push_pkt(input int s, input int len);
    for (int i = 0; i < len; i++) fq[s].push_back(mk_word(i == len - 1));
  endtask

  task automatic model_reset();
    locked = 1'b0;
    gsel   = 0;
    lastg  = N - 1;
    wcnt   = 0;
    for (int s = 0; s < N; s++) cnt[s] = 0;
    und    = '0;
  endtask

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step();
    logic [W-1:0] exp_dout;
    logic         exp_empty;
    logic [N-1:0] exp_rd;
    @(negedge clk156);
    for (int s = 0; s < N; s++) begin
      drv_w[s] = (fq[s].size() > 0) ? fq[s][0] : junk(s);
      drv_e[s] = (fq[s].size() == 0) || force_empty[s] || ($urandom_range(99) < stall_pct);
    end
    src_dout  = {drv_w[1], drv_w[0]};
    src_empty = {drv_e[1], drv_e[0]};
    rd_en     = ($urandom_range(99) < rd_pct);
    #1;
    exp_dout  = locked ? drv_w[gsel] : '0;
    exp_empty = locked ? drv_e[gsel] : 1'b1;
    exp_rd    = (locked && rd_en && !drv_e[gsel]) ? 2'(1 << gsel) : 2'b00;
    chk("empty", 128'(empty), 128'(exp_empty));
    chk("dout", 128'(dout), 128'(exp_dout));
    chk("src_rd_en", 128'(src_rd_en), 128'(exp_rd));
    chk("grant_valid", 128'(grant_valid), 128'(locked));
    chk("grant_sel", 128'(grant_sel), 128'(gsel));
    chk("pkt_cnt", 128'(pkt_cnt), 128'({4'(cnt[1]), 4'(cnt[0])}));
    chk("underrun", 128'(underrun), 128'(und));
    @(posedge clk156);
    if (!locked) begin
      for (int k = 1; k <= N; k++) begin
        if (!locked && !drv_e[(lastg + k) % N]) begin
          locked = 1'b1;
          gsel   = (lastg + k) % N;
          wcnt   = 0;
          grant_log.push_back(gsel);
        end
      end
    end else if (rd_en) begin
      if (drv_e[gsel]) begin
        und[gsel] = 1'b1;
      end else begin
        logic [W-1:0] w;
        w = fq[gsel].pop_front();
        wcnt++;
        if (w[TLAST_BIT]) begin
          cnt[gsel] = (cnt[gsel] + 1) % (1 << CW);
          lastg     = gsel;
          locked    = 1'b0;
        end
      end
    end
  endtask

  // Assert reset asynchronously (2 time units after an edge) and check at once.
  task automatic reset_and_check(input string tag);
    #2;
    sys_rst = 1'b1;
    #1;
    chk({tag, "_empty"}, 128'(empty), 128'(1'b1));
    chk({tag, "_dout"}, 128'(dout), 128'(0));
    chk({tag, "_rd"}, 128'(src_rd_en), 128'(0));
    chk({tag, "_gv"}, 128'(grant_valid), 128'(0));
    chk({tag, "_gs"}, 128'(grant_sel), 128'(0));
    chk({tag, "_cnt"}, 128'(pkt_cnt), 128'(0));
    chk({tag, "_und"}, 128'(underrun), 128'(0));
    model_reset();
    src_empty = '1;
    rd_en     = 1'b0;
    @(negedge clk156);
    sys_rst = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    force_empty = '0;
    stall_pct   = 0;
    rd_pct      = 100;
    while ((fq[0].size() > 0 || fq[1].size() > 0 || locked) && b < 400) begin
      step();
      b++;
    end
    if (b >= 400) chk("drain_timeout", 128'(b), 128'(0));
  endtask

  initial begin
    sys_rst = 1'b0;
    rd_en = 1'b0;
    src_empty = '1;
    src_dout = '0;
    force_empty = '0;
    rd_pct = 0;
    stall_pct = 0;
    model_reset();
    reset_and_check("por");

    // Single 3-word packet from src0.
    push_pkt(0, 3);
    rd_pct = 100;
    repeat (6) step();
    #1;
    chk("single_cnt", 128'(pkt_cnt), 128'(8'h01));
    chk("single_grant", 128'(grant_log[0]), 128'(0));

    // Directed underrun on src1.
    push_pkt(1, 2);
    rd_pct = 0;
    step();
    force_empty = 2'b10;
    rd_pct = 100;
    step();
    force_empty = 2'b00;
    drain();
    #1;
    chk("und_sticky", 128'(underrun), 128'(2'b10));

    // Both sources busy, 4 packets each: grants must alternate.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1 + int'($urandom_range(3)));
      push_pkt(1, 1 + int'($urandom_range(3)));
    end
    drain();
    #1;
    chk("alt_len", 128'(grant_log.size()), 128'(8));
    for (int i = 0; i < grant_log.size(); i++) chk("alt_order", 128'(grant_log[i]), 128'(i % 2));
    chk("alt_cnt", 128'(pkt_cnt), 128'(8'h55));

    // src1 stalls mid-packet for 10 cycles while src0 waits.
    grant_log.delete();
    push_pkt(1, 3);
    rd_pct = 0;
    step();
    rd_pct = 100;
    step();
    push_pkt(0, 2);
    force_empty = 2'b10;
    repeat (10) step();
    force_empty = 2'b00;
    drain();
    chk("stall_n", 128'(grant_log.size()), 128'(2));
    chk("stall_g0", 128'(grant_log[0]), 128'(1));
    chk("stall_g1", 128'(grant_log[1]), 128'(0));

    // Random traffic with random stalls and reads.
    rd_pct = 70;
    stall_pct = 15;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) push_pkt(int'($urandom_range(1)), 1 + int'($urandom_range(4)));
      step();
    end
    drain();

    // Reset after the 2nd of 4 words.
    push_pkt(0, 4);
    push_pkt(1, 4);
    rd_pct = 100;
    begin
      int b;
      b = 0;
      while (!(locked && wcnt == 2) && b < 40) begin
        step();
        b++;
      end
      if (b >= 40) chk("midrst_timeout", 128'(b), 128'(0));
    end
    reset_and_check("midrst");
    step();
    #1;
    chk("rst_first_gv", 128'(grant_valid), 128'(1));
    chk("rst_first_gs", 128'(grant_sel), 128'(0));
    drain();

    // Counter wrap with 17 single-word packets.
    reset_and_check("wraprst");
    for (int i = 0; i < 17; i++) push_pkt(0, 1);
    drain();
    #1;
    chk("wrap", 128'(pkt_cnt[CW-1:0]), 128'(4'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
